// File: rtl/dff_bank_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dff_bank_pkg
// Shared definitions for the D-FF bank arbiter slice:
//   - state_t  : two-state arbiter FSM encoding (ST_ARB / ST_GNT)
//   - DEF_*    : default NREQ / WIDTH / DEPTH
//   - rr_pick  : round-robin winner selection, returns a one-hot vector
//   - oh_to_idx: one-hot to binary index conversion
// Functions work on a fixed MAX_NREQ-wide vector so that any NREQ in 2..8
// can share them; callers zero-extend their request vector.
// -----------------------------------------------------------------------------
package dff_bank_pkg;

    typedef enum logic {
        ST_ARB = 1'b0,
        ST_GNT = 1'b1
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int MAX_NREQ  = 8;

    // First requester with its bit set, scanning upward from last+1 modulo n.
    function automatic logic [MAX_NREQ-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] req,
        input logic [2:0]          last,
        input int                  n
    );
        logic [MAX_NREQ-1:0] pick;
        logic                found;
        logic [2:0]          idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_NREQ; k++) begin
            if (k <= n) begin
                idx = 3'((int'(last) + k) % n);
                if (!found && req[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return pick;
    endfunction

    function automatic logic [2:0] oh_to_idx(input logic [MAX_NREQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter_if
// Requester / read bus of the D-FF bank arbiter.
//   Req    : per-requester write request (level)
//   Addr   : packed write addresses, requester i at [i*AW +: AW]
//   Din    : packed write data, requester i at [i*WIDTH +: WIDTH]
//   Gnt    : one-hot registered grant
//   Busy   : high while the arbiter is in its grant state
//   RdAddr : read address
//   Q      : combinational read data
//   Lock   : per-requester burst lock (only with DFF_BANK_LOCK_EN defined)
// Modports: master = requester/reader side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dff_bank_arbiter_if
    import dff_bank_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = 2
);
    logic [NREQ-1:0]       Req;
    logic [NREQ*AW-1:0]    Addr;
    logic [NREQ*WIDTH-1:0] Din;
    logic [NREQ-1:0]       Gnt;
    logic                  Busy;
    logic [AW-1:0]         RdAddr;
    logic [WIDTH-1:0]      Q;
`ifdef DFF_BANK_LOCK_EN
    logic [NREQ-1:0]       Lock;

    modport master (output Req, Addr, Din, RdAddr, Lock, input Gnt, Busy, Q);
    modport slave  (input Req, Addr, Din, RdAddr, Lock, output Gnt, Busy, Q);
`else
    modport master (output Req, Addr, Din, RdAddr, input Gnt, Busy, Q);
    modport slave  (input Req, Addr, Din, RdAddr, output Gnt, Busy, Q);
`endif
endinterface

// File: rtl/dff_bank_word.sv
// -----------------------------------------------------------------------------
// dff_bank_word
// One WIDTH-bit storage word built from D-FFs, with write enable and
// asynchronous active-low clear.
//   Cp   : clock, posedge
//   Rn   : async active-low clear
//   i_we : write enable
//   i_d  : write data
//   o_q  : stored word
// -----------------------------------------------------------------------------
module dff_bank_word #(
    parameter int WIDTH = 8
) (
    input  logic             Cp,
    input  logic             Rn,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    // NOTE: the storage words are cleared by reset like any other register,
    // so the bank reads as all zeros straight out of reset.
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge Cp or negedge Rn) begin
        if (!Rn) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter
// Round-robin arbiter sharing one D-FF bank (DEPTH x WIDTH) between NREQ
// write requesters. Each write takes an ARB edge (grant) and a GNT edge
// (commit), so the bank sees at most one write per edge.
//   Cp   : clock, posedge
//   Rn   : asynchronous active-low reset
//   bus  : dff_bank_arbiter_if.slave (Req, Addr, Din, Gnt, Busy, RdAddr, Q,
//          and Lock when DFF_BANK_LOCK_EN is defined)
// Optional feature macro: DFF_BANK_LOCK_EN -- a requester holding Lock at its
// commit edge keeps the pointer and wins the next arbitration (burst writes).
// -----------------------------------------------------------------------------
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic               Cp,
    input logic               Rn,
    dff_bank_arbiter_if.slave bus
);
    state_t              r_state;
    logic [NREQ-1:0]     r_gnt;
    logic [2:0]          r_last;   // last committed requester
    logic [2:0]          r_idx;    // requester currently / most recently granted
    logic                r_hold;   // r_idx must win the next arbitration

    logic [MAX_NREQ-1:0] w_req_ext;
    logic [MAX_NREQ-1:0] w_rr_oh;
    logic [MAX_NREQ-1:0] w_win_oh;
    logic [2:0]          w_win_idx;
    logic                w_any;
    logic                w_we;
    logic [AW-1:0]       w_waddr;
    logic [WIDTH-1:0]    w_wdata;
    logic                w_lock_cur;
    logic [WIDTH-1:0]    w_bank [DEPTH];

    assign w_req_ext = MAX_NREQ'(bus.Req);
    assign w_any     = |bus.Req;
    assign w_rr_oh   = rr_pick(w_req_ext, r_last, NREQ);

    // NOTE: every always_comb output gets a default before any condition so
    // no path leaves it unassigned (which would infer a latch).
    always_comb begin
        w_win_oh = w_rr_oh;
        if (r_hold && w_req_ext[r_idx]) begin
            w_win_oh        = '0;
            w_win_oh[r_idx] = 1'b1;
        end
    end

    assign w_win_idx = oh_to_idx(w_win_oh);

`ifdef DFF_BANK_LOCK_EN
    logic [MAX_NREQ-1:0] w_lock_ext;
    assign w_lock_ext = MAX_NREQ'(bus.Lock);
    assign w_lock_cur = w_lock_ext[r_idx];
`else
    assign w_lock_cur = 1'b0;
`endif

    // Commit only if the granted requester still asserts Req at the GNT edge.
    assign w_we    = (r_state == ST_GNT) && w_req_ext[r_idx];
    assign w_waddr = bus.Addr[int'(r_idx)*AW +: AW];
    assign w_wdata = bus.Din[int'(r_idx)*WIDTH +: WIDTH];

    always_ff @(posedge Cp or negedge Rn) begin
        if (!Rn) begin
            r_state <= ST_ARB;
            r_gnt   <= '0;
            r_last  <= 3'(NREQ - 1);
            r_idx   <= '0;
            r_hold  <= 1'b0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    // A hold is consumed by this evaluation whether or not
                    // the locked requester is still asking.
                    r_hold <= 1'b0;
                    if (w_any) begin
                        r_gnt   <= NREQ'(1) << w_win_idx;
                        r_idx   <= w_win_idx;
                        r_state <= ST_GNT;
                    end
                end
                ST_GNT: begin
                    r_gnt   <= '0;
                    r_state <= ST_ARB;
                    if (w_lock_cur) begin
                        r_hold <= 1'b1;
                    end else begin
                        r_last <= r_idx;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

    for (genvar j = 0; j < DEPTH; j++) begin : g_word
        dff_bank_word #(.WIDTH(WIDTH)) u_word (
            .Cp   (Cp),
            .Rn   (Rn),
            .i_we (w_we && (w_waddr == AW'(j))),
            .i_d  (w_wdata),
            .o_q  (w_bank[j])
        );
    end

    assign bus.Gnt  = r_gnt;
    assign bus.Busy = (r_state == ST_GNT);
    assign bus.Q    = w_bank[bus.RdAddr];
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dff_bank_arbiter
// Directed bench for dff_bank_arbiter (default NREQ=4, WIDTH=8, DEPTH=4).
// Lock scenarios are compiled in when DFF_BANK_LOCK_EN is defined.
// -----------------------------------------------------------------------------
module tb_dff_bank_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic Cp = 1'b0;
    logic Rn = 1'b0;
    always #5 Cp = ~Cp;

    dff_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) bus ();

    dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .Cp  (Cp),
        .Rn  (Rn),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Cp);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int d);
        bus.Addr[i*AW +: AW]       = AW'(a);
        bus.Din[i*WIDTH +: WIDTH]  = WIDTH'(d);
    endtask

    task automatic rd_check(input string tag, input int a, input int exp);
        bus.RdAddr = AW'(a);
        #1;
        check(tag, 32'(bus.Q), 32'(exp));
    endtask

    initial begin
        bus.Req    = '0;
        bus.Addr   = '0;
        bus.Din    = '0;
        bus.RdAddr = '0;
`ifdef DFF_BANK_LOCK_EN
        bus.Lock   = '0;
`endif

        // Reset state
        #12;
        check("rst_gnt",  32'(bus.Gnt),  32'h0);
        check("rst_busy", 32'(bus.Busy), 32'h0);
        rd_check("rst_q2", 2, 8'h00);
        Rn = 1'b1;
        tick();

        // Reset asserted mid-GNT drops the pending write
        set_req(0, 2, 8'hA5);
        bus.Req = 4'b0001;
        tick();
        check("midgnt_gnt", 32'(bus.Gnt), 32'h1);
        check("midgnt_busy", 32'(bus.Busy), 32'h1);
        Rn = 1'b0;
        #1;
        check("midrst_gnt", 32'(bus.Gnt), 32'h0);
        check("midrst_busy", 32'(bus.Busy), 32'h0);
        bus.Req = '0;
        Rn = 1'b1;
        rd_check("midrst_q2", 2, 8'h00);
        tick();
        check("idle_gnt", 32'(bus.Gnt), 32'h0);

        // Single uncontended write by requester 1
        set_req(1, 1, 8'h3C);
        bus.Req = 4'b0010;
        tick();
        check("single_gnt", 32'(bus.Gnt), 32'h2);
        check("single_busy", 32'(bus.Busy), 32'h1);
        rd_check("single_old_q1", 1, 8'h00);
        tick();
        check("single_gnt_off", 32'(bus.Gnt), 32'h0);
        check("single_busy_off", 32'(bus.Busy), 32'h0);
        rd_check("single_q1", 1, 8'h3C);
        bus.Req = '0;

        // Priority after rotation: last=1, Req=0101 -> 2 then 0
        set_req(0, 0, 8'h11);
        set_req(2, 2, 8'h22);
        bus.Req = 4'b0101;
        tick();
        check("prio_gnt_a", 32'(bus.Gnt), 32'h4);
        tick();
        check("prio_gap", 32'(bus.Gnt), 32'h0);
        tick();
        check("prio_gnt_b", 32'(bus.Gnt), 32'h1);
        tick();
        bus.Req = '0;
        rd_check("prio_q2", 2, 8'h22);
        rd_check("prio_q0", 0, 8'h11);

        // Abandoned request: Req2 drops in its GNT cycle
        set_req(2, 3, 8'hFF);
        bus.Req = 4'b0100;
        tick();
        check("aband_gnt", 32'(bus.Gnt), 32'h4);
        bus.Req = '0;
        tick();
        check("aband_gnt_off", 32'(bus.Gnt), 32'h0);
        check("aband_busy_off", 32'(bus.Busy), 32'h0);
        rd_check("aband_q3", 3, 8'h00);
        // last=2, so requester 3 beats requester 0
        set_req(3, 3, 8'h77);
        bus.Req = 4'b1001;
        tick();
        check("aband_next", 32'(bus.Gnt), 32'h8);
        tick();
        bus.Req = '0;
        rd_check("aband_q3_new", 3, 8'h77);

        // Full contention: 8 grants rotate 0,1,2,3,0,1,2,3 with gaps
        for (int i = 0; i < NREQ; i++) set_req(i, i, 8'hC0 + i);
        bus.Req = 4'b1111;
        for (int g = 0; g < 8; g++) begin
            tick();
            check($sformatf("rr_gnt%0d", g), 32'(bus.Gnt), 32'(1 << (g % 4)));
            check($sformatf("rr_busy%0d", g), 32'(bus.Busy), 32'h1);
            tick();
            check($sformatf("rr_gap%0d", g), 32'(bus.Gnt), 32'h0);
        end
        bus.Req = '0;
        for (int i = 0; i < DEPTH; i++)
            rd_check($sformatf("rr_q%0d", i), i, 8'hC0 + i);

`ifdef DFF_BANK_LOCK_EN
        // Lock burst: requester 0 writes three times, then requester 3
        set_req(0, 0, 8'hA0);
        set_req(3, 3, 8'h33);
        bus.Req  = 4'b1001;
        bus.Lock = 4'b0001;
        tick();
        check("lock_gnt1", 32'(bus.Gnt), 32'h1);
        tick();
        set_req(0, 1, 8'hA1);
        tick();
        check("lock_gnt2", 32'(bus.Gnt), 32'h1);
        tick();
        set_req(0, 2, 8'hA2);
        tick();
        check("lock_gnt3", 32'(bus.Gnt), 32'h1);
        bus.Lock = '0;
        tick();
        bus.Req = 4'b1000;
        tick();
        check("lock_release", 32'(bus.Gnt), 32'h8);
        tick();
        bus.Req = '0;
        rd_check("lock_q0", 0, 8'hA0);
        rd_check("lock_q1", 1, 8'hA1);
        rd_check("lock_q2", 2, 8'hA2);
        rd_check("lock_q3", 3, 8'h33);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
